// File: rtl/arr_multiplier_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : arr_multiplier_pipe
// Description : Pipelined WIDTH x WIDTH array multiplier, unsigned or
//               two's-complement (Baugh-Wooley) selected per transaction.
//               One register stage per partial-product row, so the latency
//               is WIDTH register stages. Valid/ready on both sides, with a
//               global stall when the output is held by the consumer.
// Ports       : Clk      - rising-edge clock
//               Reset    - asynchronous, active-high reset
//               InValid  - operand pair present on InA/InB/Signed
//               InReady  - pipeline accepts an operand pair this cycle
//               InA      - multiplicand (WIDTH bits)
//               InB      - multiplier (WIDTH bits)
//               Signed   - 1 = two's-complement operands, 0 = unsigned
//               OutValid - Out holds a valid product
//               OutReady - consumer accepts Out this cycle
//               Out      - product (2*WIDTH bits)
// Revision    : 1.0 - initial pipelined release
// ============================================================================
module arr_multiplier_pipe #(
    parameter int WIDTH = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   InA,
    input  logic [WIDTH-1:0]   InB,
    input  logic               Signed,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [2*WIDTH-1:0] Out
);

    localparam int PW = 2 * WIDTH;

    // Baugh-Wooley correction: +1 at bit WIDTH and +1 at bit 2*WIDTH-1.
    localparam logic [PW-1:0] c_bw_const = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    // Per-stage state. Operands only need to travel as far as the stage
    // that consumes the last multiplier bit, hence WIDTH-1 copies.
    logic              r_vld [WIDTH];
    logic [PW-1:0]     r_sum [WIDTH];
    logic [WIDTH-1:0]  r_a   [WIDTH-1];
    logic [WIDTH-1:0]  r_b   [WIDTH-1];
    logic              r_sgn [WIDTH-1];

    logic [PW-1:0]     w_row [WIDTH];
    logic              w_stall;
    logic              w_en;

    // Partial-product row k, already shifted into product position. In
    // signed mode a bit is inverted when exactly one of its two factors is
    // an operand MSB.
    function automatic logic [PW-1:0] pp_row(
        input logic [WIDTH-1:0] a,
        input logic             b_bit,
        input logic             sgn,
        input int               k
    );
        logic [WIDTH-1:0] row;
        logic [PW-1:0]    ext;
        for (int j = 0; j < WIDTH; j++) begin
            row[j] = (a[j] & b_bit) ^ (sgn & ((j == WIDTH - 1) != (k == WIDTH - 1)));
        end
        ext = {{WIDTH{1'b0}}, row};
        return ext << k;
    endfunction

    assign w_stall  = r_vld[WIDTH-1] & ~OutReady;
    assign w_en     = ~w_stall;
    assign InReady  = ~w_stall;
    assign OutValid = r_vld[WIDTH-1];
    assign Out      = r_sum[WIDTH-1];

    // Row adders: stage 0 seeds the running sum with row 0 (plus the signed
    // correction constant); each later stage adds one row to the sum held
    // by the stage before it.
    always_comb begin
        w_row[0] = pp_row(InA, InB[0], Signed, 0) + (Signed ? c_bw_const : '0);
        for (int k = 1; k < WIDTH; k++) begin
            w_row[k] = r_sum[k-1] + pp_row(r_a[k-1], r_b[k-1][k], r_sgn[k-1], k);
        end
    end

    // Data registers load only when a valid item moves into the stage, so
    // bubbles leave the previous contents (and therefore Out) untouched and
    // undriven operands during bubbles never reach the datapath.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < WIDTH; k++) begin
                r_vld[k] <= 1'b0;
                r_sum[k] <= '0;
            end
            for (int k = 0; k < WIDTH - 1; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sgn[k] <= 1'b0;
            end
        end else if (w_en) begin
            r_vld[0] <= InValid;
            if (InValid) begin
                r_a[0]   <= InA;
                r_b[0]   <= InB;
                r_sgn[0] <= Signed;
                r_sum[0] <= w_row[0];
            end
            for (int k = 1; k < WIDTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_sum[k] <= w_row[k];
                end
            end
            for (int k = 1; k < WIDTH - 1; k++) begin
                if (r_vld[k-1]) begin
                    r_a[k]   <= r_a[k-1];
                    r_b[k]   <= r_b[k-1];
                    r_sgn[k] <= r_sgn[k-1];
                end
            end
        end
    end

endmodule
`default_nettype wire
